// File: rtl/simple_stage_pkg.sv
// Shared constants and bank-state type for the stage memory wrapper.
package simple_stage_pkg;

  localparam int TAP_W_DEF      = 192;
  localparam int TAP_DEPTH_DEF  = 16;
  localparam int BIAS_W_DEF     = 32;
  localparam int BIAS_DEPTH_DEF = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int DATA_DEPTH_DEF = 64;

  // Number of data banks that may be full at once (both halves of the ping-pong).
  localparam logic [1:0] FULL_MAX = 2'd2;

  // Ping-pong bookkeeping: fill bank, read bank and count of full banks.
  typedef struct packed {
    logic       wb;
    logic       rb;
    logic [1:0] full_cnt;
  } bank_state_t;

endpackage

// File: rtl/simple_stage_mem_bank.sv
// Single-bank 1R1W RAM with one-cycle registered read and write-first bypass.
module simple_stage_mem_bank #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);

  logic [W-1:0] mem [DEPTH];

  // Storage write; contents are not cleared by reset, but reset blocks writes.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_addr] <= wr_data;
  end

  // Registered read: same-cycle write to the read address returns the new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/simple_stage_pingpong_mem.sv
// Per-stage tap/bias memories plus a double-buffered data memory between
// the stage loader (write side) and the MAC datapath (read side).
module simple_stage_pingpong_mem
  import simple_stage_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int TAP_DEPTH  = TAP_DEPTH_DEF,
  parameter int BIAS_W     = BIAS_W_DEF,
  parameter int BIAS_DEPTH = BIAS_DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF,
  localparam int TAP_AW    = $clog2(TAP_DEPTH),
  localparam int BIAS_AW   = $clog2(BIAS_DEPTH),
  localparam int DATA_AW   = $clog2(DATA_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tap_wr_en,
  input  logic [TAP_AW-1:0]  tap_wr_addr,
  input  logic [TAP_W-1:0]   tap_wr_data,
  input  logic               tap_rd_en,
  input  logic [TAP_AW-1:0]  tap_rd_addr,
  output logic [TAP_W-1:0]   tap_rd_data,
  output logic               tap_rd_valid,
  input  logic               bias_wr_en,
  input  logic [BIAS_AW-1:0] bias_wr_addr,
  input  logic [BIAS_W-1:0]  bias_wr_data,
  input  logic               bias_rd_en,
  input  logic [BIAS_AW-1:0] bias_rd_addr,
  output logic [BIAS_W-1:0]  bias_rd_data,
  output logic               bias_rd_valid,
  input  logic               data_wr_en,
  input  logic [DATA_AW-1:0] data_wr_addr,
  input  logic [DATA_W-1:0]  data_wr_data,
  input  logic               data_wr_last,
  output logic               data_wr_ready,
  input  logic               data_rd_en,
  input  logic [DATA_AW-1:0] data_rd_addr,
  input  logic               data_rd_done,
  output logic [DATA_W-1:0]  data_rd_data,
  output logic               data_rd_valid,
  output logic               data_avail,
  output logic               data_err
);

  bank_state_t st;
  logic        rd_sel;   // bank that served the most recent data read

  logic wr_acc, wr_fill_done, rd_acc, done_acc, proto_err;

  logic [1:0]             bank_wr_en;
  logic [1:0]             bank_rd_en;
  logic [1:0]             bank_rd_valid;
  logic [1:0][DATA_W-1:0] bank_rd_data;

  // Handshake decodes come straight off the registered full count.
  assign data_wr_ready = (st.full_cnt < FULL_MAX);
  assign data_avail    = (st.full_cnt != 2'd0);

  assign wr_acc       = data_wr_en & data_wr_ready;
  assign wr_fill_done = wr_acc & data_wr_last;
  assign rd_acc       = data_rd_en & data_avail;
  assign done_acc     = data_rd_done & data_avail;
  assign proto_err    = (data_wr_en & ~data_wr_ready) |
                        (data_rd_en & ~data_avail) |
                        (data_rd_done & ~data_avail);

  // Ping-pong pointers and full count; fill-complete and release cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= '0;
    end else begin
      if (wr_fill_done) st.wb <= ~st.wb;
      if (done_acc)     st.rb <= ~st.rb;
      case ({wr_fill_done, done_acc})
        2'b10:   st.full_cnt <= st.full_cnt + 2'd1;
        2'b01:   st.full_cnt <= st.full_cnt - 2'd1;
        default: st.full_cnt <= st.full_cnt;
      endcase
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) data_err <= 1'b0;
    else if (proto_err) data_err <= 1'b1;
  end

  // Remember which bank a read came from so a same-cycle release can't
  // redirect the returning data to the other bank.
  always_ff @(posedge clk) begin
    if (reset) rd_sel <= 1'b0;
    else if (rd_acc) rd_sel <= st.rb;
  end

  // Route accepted writes/reads to the fill/read bank respectively.
  always_comb begin
    bank_wr_en = '0;
    bank_rd_en = '0;
    bank_wr_en[st.wb] = wr_acc;
    bank_rd_en[st.rb] = rd_acc;
  end

  for (genvar b = 0; b < 2; b++) begin : g_data_bank
    simple_stage_mem_bank #(.W(DATA_W), .DEPTH(DATA_DEPTH)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (bank_wr_en[b]),
      .wr_addr  (data_wr_addr),
      .wr_data  (data_wr_data),
      .rd_en    (bank_rd_en[b]),
      .rd_addr  (data_rd_addr),
      .rd_data  (bank_rd_data[b]),
      .rd_valid (bank_rd_valid[b])
    );
  end

  assign data_rd_data  = bank_rd_data[rd_sel];
  assign data_rd_valid = |bank_rd_valid;

  simple_stage_mem_bank #(.W(TAP_W), .DEPTH(TAP_DEPTH)) u_tap (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (tap_wr_en),
    .wr_addr  (tap_wr_addr),
    .wr_data  (tap_wr_data),
    .rd_en    (tap_rd_en),
    .rd_addr  (tap_rd_addr),
    .rd_data  (tap_rd_data),
    .rd_valid (tap_rd_valid)
  );

  simple_stage_mem_bank #(.W(BIAS_W), .DEPTH(BIAS_DEPTH)) u_bias (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bias_wr_en),
    .wr_addr  (bias_wr_addr),
    .wr_data  (bias_wr_data),
    .rd_en    (bias_rd_en),
    .rd_addr  (bias_rd_addr),
    .rd_data  (bias_rd_data),
    .rd_valid (bias_rd_valid)
  );

endmodule

// File: doc/simple_stage_pingpong_mem.md
Name: simple_stage_pingpong_mem

Overview:
- Parametrised successor to the per-stage tap/bias/data memory wrapper of the simple network pipeline.
- Holds tap and bias coefficients in single-bank 1R1W RAMs with configurable width and depth.
- Double-buffers (ping-pong) the data memory, so the producer fills the next input vector while the stage datapath reads the current one.
- Sits between the stage loader (write side) and the stage MAC datapath (read side).

Parameters:
- TAP_W, 192, tap word width (bits)
- TAP_DEPTH, 16, tap words
- BIAS_W, 32, bias word width
- BIAS_DEPTH, 16, bias words
- DATA_W, 32, data word width
- DATA_DEPTH, 64, data words per bank
- Derived, not overridable: TAP_AW = $clog2(TAP_DEPTH), BIAS_AW = $clog2(BIAS_DEPTH), DATA_AW = $clog2(DATA_DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- tap_wr_en / tap_wr_addr / tap_wr_data  in  1 / TAP_AW / TAP_W  tap write
- tap_rd_en / tap_rd_addr  in  1 / TAP_AW  tap read request
- tap_rd_data / tap_rd_valid  out  TAP_W / 1  tap read result
- bias_wr_en / bias_wr_addr / bias_wr_data  in  1 / BIAS_AW / BIAS_W  bias write
- bias_rd_en / bias_rd_addr  in  1 / BIAS_AW  bias read request
- bias_rd_data / bias_rd_valid  out  BIAS_W / 1  bias read result
- data_wr_en / data_wr_addr / data_wr_data  in  1 / DATA_AW / DATA_W  write into current fill bank
- data_wr_last  in  1  qualified by data_wr_en; marks fill bank complete
- data_wr_ready  out  1  a fill bank is free (full_cnt < 2)
- data_rd_en / data_rd_addr  in  1 / DATA_AW  read from current read bank
- data_rd_done  in  1  consumer releases current read bank
- data_rd_data / data_rd_valid  out  DATA_W / 1  data read result
- data_avail  out  1  a full bank is readable (full_cnt > 0)
- data_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all rd_valid = 0, all rd_data = 0, wb = 0, rb = 0, full_cnt = 0, data_err = 0, data_wr_ready = 1, data_avail = 0. RAM contents are not reset. Reset dominates all inputs in the same cycle and aborts a partial fill.
- Read latency for all three memories: 1 cycle. The rd_en edge registers rd_valid = 1 and rd_data = mem[addr]; the following cycle has rd_valid = 0 unless rd_en is asserted again. rd_data holds its last value while idle.
- Tap/bias same-cycle write and read to the same address: write-first; rd_data returns the new wr_data.
- Ping-pong state: wb (fill bank), rb (read bank), full_cnt in 0..2.
  - Accepted write (data_wr_en & data_wr_ready): writes bank[wb][addr].
  - If data_wr_last is also set: wb toggles and full_cnt increments.
- Write while data_wr_ready = 0: dropped; data_err set.
- Read (data_rd_en & data_avail): reads bank[rb][addr].
- Read with data_avail = 0: ignored, no rd_valid; data_err set.
- data_rd_done with data_avail = 1: rb toggles, full_cnt decrements. data_rd_done with data_avail = 0: ignored; data_err set.
- data_rd_en and data_rd_done in the same cycle: the read is served from the old rb; the toggle takes effect next cycle.
- Accepted last and done in the same cycle: full_cnt unchanged, both pointers toggle.
- Under legal use, read and fill banks never collide. When full_cnt = 0 reads are blocked, so no bypass is needed on data.
- data_wr_ready and data_avail are combinational decodes of registered full_cnt.

Decomposition:
- Shared package simple_stage_pkg:
  - default width/depth constants
  - bank-state typedef (wb, rb, full_cnt[1:0])
  - localparam FULL_MAX = 2
- Sub-module simple_stage_mem_bank (params W, DEPTH):
  - sync 1R1W RAM, registered read, write-first bypass, rd_valid register
  - instantiated 4×: tap, bias, data bank 0, data bank 1
- Top holds the ping-pong control, read/write routing with output muxing by registered rb, and error logic.

Test Plan:
- Reset, then tap write addr 3 = 0xA5..A5 (192 b); tap read addr 3 next cycle -> rd_valid one cycle later, rd_data = 0xA5..A5.
- Bias write and read addr 7 in the same cycle with wr_data 0x1234_5678 -> next cycle bias_rd_data = 0x1234_5678 (write-first).
- Fill bank 0 with data[i] = i for i = 0..63, last on 63 -> data_avail = 1, data_wr_ready = 1. Read addr 10 -> data_rd_data = 10.
- Fill bank 1 with data[i] = 100+i while reading bank 0 -> full_cnt = 2, data_wr_ready = 0. Further write -> data_err = 1. rd_done -> next read addr 5 returns 105, data_wr_ready = 1.
- Accepted last and rd_done in the same cycle with full_cnt = 1 -> full_cnt stays 1, wb and rb both toggle, data_err = 0.
- Reset mid-fill (after 20 writes) -> full_cnt = 0, data_avail = 0, data_err = 0, all rd_valid = 0. A read attempt then sets data_err with no rd_valid.
